// File: rtl/alu_div_rv32i_pkg.sv
// Shared definitions for the RV32M iterative divide unit.
package alu_div_rv32i_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned DIV_ITER = 32;
  localparam int unsigned CNT_W    = 6;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CALC   = 2'b01,
    ST_FINISH = 2'b10
  } div_state_e;

  // Operation context latched at accept; op[0]=unsigned, op[1]=remainder.
  typedef struct packed {
    logic [1:0] op;
    logic       q_neg;
    logic       r_neg;
  } div_ctx_t;

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x);
    return x[XLEN-1] ? (~x + XLEN'(1)) : x;
  endfunction

endpackage

// File: rtl/alu_div_rv32i_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module div_step_rv32i
  import alu_div_rv32i_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] dvd,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_next_c,
  output logic [XLEN-1:0] dvd_next_c,
  output logic            qbit_c
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Shifted remainder needs XLEN+1 bits once the divisor exceeds 2^(XLEN-1).
  always_comb begin
    shifted    = {rem, dvd[XLEN-1]};
    diff       = shifted - {1'b0, dvs};
    qbit_c     = (shifted >= {1'b0, dvs});
    rem_next_c = qbit_c ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    dvd_next_c = {dvd[XLEN-2:0], 1'b0};
  end

endmodule

// File: rtl/alu_div_rv32i.sv
// RV32M DIV/DIVU/REM/REMU unit: one restoring step per cycle, start/busy/done handshake.
module alu_div_rv32i
  import alu_div_rv32i_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic [1:0]      op,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] out
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  dvd_q, dvd_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  div_ctx_t         ctx_q, ctx_d;
  logic             busy_d, done_d;
  logic [XLEN-1:0]  out_d;

  logic [XLEN-1:0]  step_rem_c, step_dvd_c;
  logic             step_qbit_c;

  div_step_rv32i u_step (
    .rem        (rem_q),
    .dvd        (dvd_q),
    .dvs        (dvs_q),
    .rem_next_c (step_rem_c),
    .dvd_next_c (step_dvd_c),
    .qbit_c     (step_qbit_c)
  );

  logic            accept_c;
  logic            is_signed_c;
  logic            is_rem_c;
  logic            in_neg_c;
  logic [XLEN-1:0] quo_fin_c;
  logic [XLEN-1:0] res_fin_c;

  // Next-state, datapath and registered-output values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    ctx_d     = ctx_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    out_d     = out;
    accept_c  = start && (state_q != ST_CALC);
    is_signed_c = ~op[0];
    is_rem_c  = ctx_q.op[1];
    in_neg_c  = ~ctx_q.op[0] & (is_rem_c ? ctx_q.r_neg : ctx_q.q_neg);
    quo_fin_c = {quo_q[XLEN-2:0], step_qbit_c};
    res_fin_c = is_rem_c ? step_rem_c : quo_fin_c;

    case (state_q)
      ST_CALC: begin
        rem_d  = step_rem_c;
        dvd_d  = step_dvd_c;
        quo_d  = quo_fin_c;
        cnt_d  = cnt_q - CNT_W'(1);
        busy_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          out_d   = in_neg_c ? (~res_fin_c + XLEN'(1)) : res_fin_c;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Accept in IDLE or FINISH; corner cases resolve without iterating.
    if (accept_c) begin
      ctx_d.op    = op;
      ctx_d.q_neg = is_signed_c & (in1[XLEN-1] ^ in2[XLEN-1]);
      ctx_d.r_neg = is_signed_c & in1[XLEN-1];
      dvd_d       = is_signed_c ? abs_val(in1) : in1;
      dvs_d       = is_signed_c ? abs_val(in2) : in2;
      rem_d       = '0;
      quo_d       = '0;
      cnt_d       = CNT_W'(DIV_ITER - 1);
      if (in2 == '0) begin
        state_d = ST_FINISH;
        done_d  = 1'b1;
        out_d   = op[1] ? in1 : '1;
      end else if (is_signed_c && (in1 == INT_MIN) && (in2 == '1)) begin
        state_d = ST_FINISH;
        done_d  = 1'b1;
        out_d   = op[1] ? '0 : INT_MIN;
      end else begin
        state_d = ST_CALC;
        busy_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      ctx_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      out     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      ctx_q   <= ctx_d;
      busy    <= busy_d;
      done    <= done_d;
      out     <= out_d;
    end
  end

endmodule

// File: tb/tb_alu_div_rv32i.sv
// Self-checking bench for alu_div_rv32i: latency/arith model checked every cycle plus directed cases.
module tb_alu_div_rv32i;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [1:0]  op;
  logic        busy;
  logic        done;
  logic [31:0] out;

  int checks = 0;
  int errors = 0;

  // Model state: cycles until the done pulse, pending result, expected outputs.
  int          m_left = 0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_out  = '0;
  logic        m_post_rst = 1'b0;

  alu_div_rv32i dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .op    (op),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  always #5 clock = ~clock;

  function automatic logic is_fast(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // RISC-V truncating division semantics, straight from the ISA rules.
  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      2'b00:   return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model update at the active edge, DUT compare on the falling edge.
  task automatic cycle();
    @(posedge clock);
    if (reset) begin
      m_left     = 0;
      m_out      = '0;
      m_post_rst = 1'b1;
    end else begin
      m_post_rst = 1'b0;
      if (m_left > 0) m_left--;
      if (m_left == 0 && start) begin
        m_pend = ref_res(op, in1, in2);
        m_left = is_fast(op, in1, in2) ? 1 : 33;
      end
      if (m_left == 1) m_out = m_pend;
    end
    @(negedge clock);
    chk("busy", 32'(busy), 32'(m_left > 1));
    chk("done", 32'(done), 32'(m_left == 1));
    if (m_left == 1 || m_post_rst) chk("out", out, m_out);
  endtask

  task automatic wait_done(input logic clear_start, output int lat, output int nbusy, output logic ok);
    lat = 0; nbusy = 0; ok = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      if (clear_start) start = 1'b0;
      if (busy) nbusy++;
      if (done) begin
        lat = k; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat, input int exp_busy);
    int lat, nb;
    logic ok;
    chk({name, "_model"}, ref_res(o, a, b), exp);
    op = o; in1 = a; in2 = b; start = 1'b1;
    wait_done(1'b1, lat, nb, ok);
    chk({name, "_done_seen"}, 32'(ok), 32'd1);
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
    chk({name, "_out"}, out, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      6: return 32'(0 - $urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, nb, dones;
    logic ok;
    reset = 1'b1; start = 1'b0; in1 = '0; in2 = '0; op = 2'b00;
    repeat (3) cycle();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out", out, 32'd0);
    reset = 1'b0;
    cycle();

    do_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 32);
    do_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 32);
    do_op("div_7_m2",   2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 32);
    do_op("rem_7_m2",   2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 32);
    do_op("divu_max_2", 2'b01, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 33, 32);
    do_op("remu_max_2", 2'b11, 32'hFFFF_FFFF, 32'd2, 32'd1, 33, 32);
    do_op("remu_big",   2'b11, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 32);
    do_op("div_5_0",    2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    do_op("rem_5_0",    2'b10, 32'd5, 32'd0, 32'd5, 1, 0);
    do_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    do_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
    do_op("div_zero_dvd", 2'b00, 32'd0, 32'd5, 32'd0, 33, 32);

    // Start held with new operands during CALC, then accepted back-to-back in FINISH.
    cycle();
    op = 2'b01; in1 = 32'd1000; in2 = 32'd10; start = 1'b1;
    cycle();
    in1 = 32'd100; in2 = 32'd7;
    wait_done(1'b0, lat, nb, ok);
    chk("held_done_seen", 32'(ok), 32'd1);
    chk("held_latency", 32'(lat), 32'd32);
    chk("held_out", out, 32'h64);
    wait_done(1'b1, lat, nb, ok);
    chk("b2b_done_seen", 32'(ok), 32'd1);
    chk("b2b_latency", 32'(lat), 32'd33);
    chk("b2b_out", out, 32'd14);

    // Reset in the middle of a DIV aborts it without a done pulse.
    cycle();
    op = 2'b00; in1 = 32'd100; in2 = 32'd3; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (8) cycle();
    reset = 1'b1;
    cycle();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_out", out, 32'd0);
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    do_op("div_20_3", 2'b00, 32'd20, 32'd3, 32'd6, 33, 32);

    // Random traffic: starts land in IDLE, CALC and FINISH; occasional resets.
    for (int k = 0; k < 3000; k++) begin
      start = ($urandom_range(0, 3) == 0);
      op    = 2'($urandom_range(0, 3));
      in1   = pick();
      in2   = pick();
      reset = ($urandom_range(0, 499) == 0);
      cycle();
    end
    reset = 1'b0; start = 1'b0;
    repeat (40) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_div_rv32i.md
Name: alu_div_rv32i

Overview:
- Multi-cycle RV32M divide unit sitting beside the single-cycle ALU subblocks.
- Executes DIV, DIVU, REM and REMU using iterative restoring division (one quotient bit per cycle).
- Uses a start/busy/done handshake so the datapath can stall while a divide is in flight.
- Signed/unsigned selection and RISC-V corner-case results (divide by zero, signed overflow) are resolved inside the block.

Parameters:
- XLEN, 32, operand and result width; only 32 is supported.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; accepted only when busy=0.
- in1  input  32  dividend (rs1).
- in2  input  32  divisor (rs2).
- op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- busy  output  1  high while an iteration is in progress; start is ignored.
- done  output  1  one-cycle pulse; out is valid in that cycle.
- out  output  32  registered result, held until the next accepted start or reset.

Behaviour:
- Reset (synchronous, active-high) sets state=IDLE, busy=0, done=0, out=0, and clears all internal registers. Reset asserted mid-operation aborts the operation; no done is produced.
- States are IDLE, CALC and FINISH.
- Accept (IDLE or FINISH, start=1 at edge T):
  - Latch op.
  - For signed ops, latch the magnitudes |in1| and |in2|, plus sign flags: quotient sign = in1[31]^in2[31]; remainder sign = in1[31].
  - For unsigned ops, take operands as-is.
- Fast paths, decided at accept:
  - Divide by zero (in2=0): result is 0xFFFFFFFF for DIV/DIVU and in1 for REM/REMU. Go directly to FINISH; done=1 in cycle T+1.
  - Signed overflow (DIV/REM with in1=0x80000000, in2=0xFFFFFFFF): result is 0x80000000 for DIV and 0 for REM. Go directly to FINISH; done=1 in cycle T+1.
- CALC:
  - A 6-bit counter runs 31 down to 0; one restoring step per cycle.
  - Each step: rem = {rem[30:0], dvd[31]}; dvd shifts left by 1.
  - If rem >= dvs (unsigned 33-bit compare): rem -= dvs and quotient bit = 1; otherwise quotient bit = 0.
  - Exit to FINISH after the step with counter=0. CALC occupies cycles T+1..T+32.
- FINISH:
  - out is loaded from the quotient (DIV/DIVU) or remainder (REM/REMU), negated (two's complement) when the applicable sign flag is set for signed ops.
  - For a normal operation, done=1 and out are valid in cycle T+33. Latency is 33 cycles normally and 1 cycle on a fast path.
  - Next state is IDLE, unless start=1, which is accepted immediately (back-to-back).
- busy=1 exactly in CALC. start during CALC is ignored: operands are not relatched and the in-flight result is unaffected.
- done is never asserted for two consecutive cycles for the same operation.
- A zero dividend takes the normal path and yields quotient 0 and remainder 0.
- Output signs follow RISC-V truncating division: the remainder takes the sign of the dividend.

Decomposition:
- Shared package holds:
  - op encodings: OP_DIV=2'b00, OP_DIVU=2'b01, OP_REM=2'b10, OP_REMU=2'b11.
  - state encodings for IDLE, CALC and FINISH.
  - constant DIV_ITER=32.
- One natural sub-module, div_step_rv32i: combinational single restoring step.
  - Inputs: rem, dvd, dvs.
  - Outputs: next rem, next dvd, quotient bit.
  - Instantiated once per cycle in CALC.
- FSM, counter, sign handling and fast paths stay in the top-level module.

Test Plan:
- DIV in1=0xFFFFFFF9 (-7), in2=2 -> done at T+33, out=0xFFFFFFFD (-3); REM same operands -> out=0xFFFFFFFF (-1).
- DIVU in1=0xFFFFFFFF, in2=2 -> out=0x7FFFFFFF; REMU -> out=1; busy high for exactly 32 cycles.
- Divide by zero: DIV 5/0 -> out=0xFFFFFFFF at T+1; REM 5/0 -> out=5; busy never asserted.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> out=0x80000000 at T+1; REM -> out=0.
- Start held with new operands (100/7 DIVU) during CALC of 1000/10 DIVU -> out=100 (0x64), no relatch; then back-to-back start in FINISH cycle of 100/7 -> second out=14.
- Reset asserted at T+10 of a DIV -> next cycle busy=0, done=0, out=0; no done pulse follows; a fresh DIV 20/3 then returns 6.
